// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : SVGA 800x600@72Hz raster timing constants shared by the generator
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int POS_W  = 10;

    localparam int DEF_H_VIS = 800;
    localparam int DEF_H_FP  = 56;
    localparam int DEF_H_SW  = 120;
    localparam int DEF_H_BP  = 64;
    localparam int DEF_V_VIS = 600;
    localparam int DEF_V_FP  = 37;
    localparam int DEF_V_SW  = 6;
    localparam int DEF_V_BP  = 23;

    localparam int DEF_H_TOT      = DEF_H_VIS + DEF_H_FP + DEF_H_SW + DEF_H_BP;
    localparam int DEF_V_TOT      = DEF_V_VIS + DEF_V_FP + DEF_V_SW + DEF_V_BP;
    localparam int DEF_HS_START   = DEF_H_VIS + DEF_H_FP;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SW;
    localparam int DEF_VS_START   = DEF_V_VIS + DEF_V_FP;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SW;

    // Maps an "inside sync window" flag onto the configured pin polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// mod_counter : modulo-(MAX+1) up counter with enable and wrap strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_counter #(
    parameter int WIDTH = 11,
    parameter int MAX   = 1039
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // wrap is combinational so a cascaded counter steps in the same cycle.
    assign wrap = en && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen : raster timing generator (HSYNC/VSYNC, x/y, valid, strobes)
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS  = DEF_H_VIS,
    parameter int   H_FP   = DEF_H_FP,
    parameter int   H_SW   = DEF_H_SW,
    parameter int   H_BP   = DEF_H_BP,
    parameter int   V_VIS  = DEF_V_VIS,
    parameter int   V_FP   = DEF_V_FP,
    parameter int   V_SW   = DEF_V_SW,
    parameter int   V_BP   = DEF_V_BP,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic             clk50,
    input  logic             rst_n,
    output logic [POS_W-1:0] h_counter,
    output logic [POS_W-1:0] v_counter,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic             newline,
    output logic             newframe
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    localparam logic [HCNT_W-1:0] H_VIS_C    = HCNT_W'(H_VIS);
    localparam logic [HCNT_W-1:0] HS_START_C = HCNT_W'(H_VIS + H_FP);
    localparam logic [HCNT_W-1:0] HS_END_C   = HCNT_W'(H_VIS + H_FP + H_SW);
    localparam logic [VCNT_W-1:0] V_VIS_C    = VCNT_W'(V_VIS);
    localparam logic [VCNT_W-1:0] VS_START_C = VCNT_W'(V_VIS + V_FP);
    localparam logic [VCNT_W-1:0] VS_END_C   = VCNT_W'(V_VIS + V_FP + V_SW);
    localparam logic [POS_W-1:0]  H_SAT_C    = '1;

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              h_wrap;
    logic              unused_v_wrap;

    mod_counter #(
        .WIDTH (HCNT_W),
        .MAX   (H_TOT - 1)
    ) u_hcnt (
        .clk   (clk50),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (hcnt),
        .wrap  (h_wrap)
    );

    mod_counter #(
        .WIDTH (VCNT_W),
        .MAX   (V_TOT - 1)
    ) u_vcnt (
        .clk   (clk50),
        .rst_n (rst_n),
        .en    (h_wrap),
        .cnt   (vcnt),
        .wrap  (unused_v_wrap)
    );

    // hcnt never exceeds 2047, so bit 10 alone flags the 1024.. region.
    assign h_counter = hcnt[HCNT_W-1] ? H_SAT_C : hcnt[POS_W-1:0];
    assign v_counter = vcnt;

    assign hsync = sync_level((hcnt >= HS_START_C) && (hcnt < HS_END_C), HS_POL);
    assign vsync = sync_level((vcnt >= VS_START_C) && (vcnt < VS_END_C), VS_POL);

    assign valid    = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    assign newline  = (hcnt == '0);
    assign newframe = (hcnt == '0) && (vcnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// tb_vga_sync_gen : scoreboard bench, full SVGA timing plus a shrunken raster
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic [9:0] a_h, a_v, b_h, b_v;
    logic a_hs, a_vs, a_vld, a_nl, a_nf;
    logic b_hs, b_vs, b_vld, b_nl, b_nf;

    vga_sync_gen dut_a (
        .clk50(clk), .rst_n(rst_n), .h_counter(a_h), .v_counter(a_v),
        .hsync(a_hs), .vsync(a_vs), .valid(a_vld), .newline(a_nl), .newframe(a_nf)
    );

    // Shrunken raster: H_TOT=15 (sync 10..12, active-low), V_TOT=11 (sync 8..9).
    vga_sync_gen #(
        .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(2),
        .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut_b (
        .clk50(clk), .rst_n(rst_n), .h_counter(b_h), .v_counter(b_v),
        .hsync(b_hs), .vsync(b_vs), .valid(b_vld), .newline(b_nl), .newframe(b_nf)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0     = 0;

    int          qa_cyc[$], qb_cyc[$];
    logic [24:0] qa_exp[$], qb_exp[$];
    string       qa_name[$], qb_name[$];

    function automatic logic [24:0] pk(int h, int v, bit hs, bit vs, bit vld, bit nl, bit nf);
        return {10'(h), 10'(v), hs, vs, vld, nl, nf};
    endfunction

    function automatic string fmt(logic [24:0] e);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b vld=%b nl=%b nf=%b",
                         e[24:15], e[14:5], e[4], e[3], e[2], e[1], e[0]);
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // p = clock edges since the last release (or since c0 was latched)
    function automatic void push_a(int p, logic [24:0] e);
        qa_cyc.push_back(c0 + 1 + p);
        qa_exp.push_back(e);
        qa_name.push_back($sformatf("A_p%0d", p));
    endfunction

    function automatic void push_b(int p, logic [24:0] e);
        qb_cyc.push_back(c0 + 1 + p);
        qb_exp.push_back(e);
        qb_name.push_back($sformatf("B_p%0d", p));
    endfunction

    // Scoreboard monitor
    initial begin
        logic [24:0] act;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            while (qa_cyc.size() > 0 && qa_cyc[0] <= cyc) begin
                act = {a_h, a_v, a_hs, a_vs, a_vld, a_nl, a_nf};
                checks++;
                if (act !== qa_exp[0] || qa_cyc[0] != cyc) begin
                    errors++;
                    $display("FAIL %s: got %s expected %s", qa_name[0], fmt(act), fmt(qa_exp[0]));
                end
                void'(qa_cyc.pop_front()); void'(qa_exp.pop_front()); void'(qa_name.pop_front());
            end
            while (qb_cyc.size() > 0 && qb_cyc[0] <= cyc) begin
                act = {b_h, b_v, b_hs, b_vs, b_vld, b_nl, b_nf};
                checks++;
                if (act !== qb_exp[0] || qb_cyc[0] != cyc) begin
                    errors++;
                    $display("FAIL %s: got %s expected %s", qb_name[0], fmt(act), fmt(qb_exp[0]));
                end
                void'(qb_cyc.pop_front()); void'(qb_exp.pop_front()); void'(qb_name.pop_front());
            end
        end
    end

    // Interval monitor: sync widths/positions, line and frame periods
    initial begin
        bit a_ok = 0, a_nl_seen = 0, a_prev_hs = 0, a_prev_vld = 0;
        int a_since = 0, a_hs_w = 0;
        bit b_ok = 0, b_seen = 0, b_prev_vs = 0;
        int b_since = 0, b_vcnt = 0, b_vsc = 0, b_hsc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_ok = 0; a_nl_seen = 0; b_ok = 0; b_seen = 0;
            end else begin
                if (a_ok) begin
                    if (a_hs && !a_prev_hs) begin chk("hsync_rise_h", int'(a_h), 856); a_hs_w = 0; end
                    if (!a_hs && a_prev_hs) begin
                        chk("hsync_fall_h", int'(a_h), 976);
                        chk("hsync_width", a_hs_w, 120);
                    end
                    if (!a_vld && a_prev_vld) chk("valid_fall_h", int'(a_h), 800);
                    if (a_vld && !a_prev_vld) chk("valid_rise_h", int'(a_h), 0);
                end
                if (a_hs) a_hs_w++;
                if (a_nl) begin
                    if (a_nl_seen) chk("line_period", a_since, 1040);
                    a_nl_seen = 1; a_since = 0;
                end
                a_since++;
                a_ok = 1; a_prev_hs = a_hs; a_prev_vld = a_vld;

                if (b_ok && b_vs && !b_prev_vs) begin
                    chk("vsync_rise_v", int'(b_v), 8);
                    chk("vsync_rise_h", int'(b_h), 0);
                end
                if (b_nf) begin
                    if (b_seen) begin
                        chk("frame_period", b_since, 165);
                        chk("valid_per_frame", b_vcnt, 48);
                        chk("vsync_clocks", b_vsc, 30);
                        chk("hsync_clocks", b_hsc, 33);
                    end
                    b_seen = 1; b_since = 0; b_vcnt = 0; b_vsc = 0; b_hsc = 0;
                end
                b_since++;
                if (b_vld) b_vcnt++;
                if (b_vs)  b_vsc++;
                if (!b_hs) b_hsc++;
                b_ok = 1; b_prev_vs = b_vs;
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        c0 = cyc;
        push_a(0, pk(0, 0, 0, 0, 1, 1, 1));
        push_a(1, pk(0, 0, 0, 0, 1, 1, 1));
        push_b(0, pk(0, 0, 1, 0, 1, 1, 1));
        push_b(1, pk(0, 0, 1, 0, 1, 1, 1));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        c0 = cyc;
        push_a(0,    pk(0,    0, 0, 0, 1, 1, 1));
        push_a(1,    pk(1,    0, 0, 0, 1, 0, 0));
        push_a(799,  pk(799,  0, 0, 0, 1, 0, 0));
        push_a(800,  pk(800,  0, 0, 0, 0, 0, 0));
        push_a(855,  pk(855,  0, 0, 0, 0, 0, 0));
        push_a(856,  pk(856,  0, 1, 0, 0, 0, 0));
        push_a(975,  pk(975,  0, 1, 0, 0, 0, 0));
        push_a(976,  pk(976,  0, 0, 0, 0, 0, 0));
        push_a(1023, pk(1023, 0, 0, 0, 0, 0, 0));
        push_a(1024, pk(1023, 0, 0, 0, 0, 0, 0));
        push_a(1039, pk(1023, 0, 0, 0, 0, 0, 0));
        push_a(1040, pk(0,    1, 0, 0, 1, 1, 0));
        push_a(1041, pk(1,    1, 0, 0, 1, 0, 0));
        push_a(2080, pk(0,    2, 0, 0, 1, 1, 0));
        push_a(3110, pk(1023, 2, 0, 0, 0, 0, 0));
        push_b(0,   pk(0,  0,  1, 0, 1, 1, 1));
        push_b(7,   pk(7,  0,  1, 0, 1, 0, 0));
        push_b(8,   pk(8,  0,  1, 0, 0, 0, 0));
        push_b(9,   pk(9,  0,  1, 0, 0, 0, 0));
        push_b(10,  pk(10, 0,  0, 0, 0, 0, 0));
        push_b(12,  pk(12, 0,  0, 0, 0, 0, 0));
        push_b(13,  pk(13, 0,  1, 0, 0, 0, 0));
        push_b(14,  pk(14, 0,  1, 0, 0, 0, 0));
        push_b(15,  pk(0,  1,  1, 0, 1, 1, 0));
        push_b(89,  pk(14, 5,  1, 0, 0, 0, 0));
        push_b(90,  pk(0,  6,  1, 0, 0, 1, 0));
        push_b(120, pk(0,  8,  1, 1, 0, 1, 0));
        push_b(149, pk(14, 9,  1, 1, 0, 0, 0));
        push_b(150, pk(0,  10, 1, 0, 0, 1, 0));
        push_b(164, pk(14, 10, 1, 0, 0, 0, 0));
        push_b(165, pk(0,  0,  1, 0, 1, 1, 1));
        push_b(166, pk(1,  0,  1, 0, 1, 0, 0));

        // Advance to big raster h=500, v=3 (small raster h=5, v=10)
        repeat (3620) @(posedge clk);
        #2;
        chk("pre_reset_a_h", int'(a_h), 500);
        chk("pre_reset_a_v", int'(a_v), 3);
        chk("pre_reset_b_h", int'(b_h), 5);
        chk("pre_reset_b_v", int'(b_v), 10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_a_h",  int'(a_h), 0);
        chk("async_rst_a_v",  int'(a_v), 0);
        chk("async_rst_a_nf", int'(a_nf), 1);
        chk("async_rst_a_hs", int'(a_hs), 0);
        chk("async_rst_b_h",  int'(b_h), 0);
        chk("async_rst_b_v",  int'(b_v), 0);
        chk("async_rst_b_hs", int'(b_hs), 1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        c0 = cyc;
        push_a(0,    pk(0,    0, 0, 0, 1, 1, 1));
        push_a(1,    pk(1,    0, 0, 0, 1, 0, 0));
        push_a(540,  pk(540,  0, 0, 0, 1, 0, 0));
        push_a(1039, pk(1023, 0, 0, 0, 0, 0, 0));
        push_a(1040, pk(0,    1, 0, 0, 1, 1, 0));
        push_b(0,    pk(0, 0, 1, 0, 1, 1, 1));
        push_b(164,  pk(14, 10, 1, 0, 0, 0, 0));
        push_b(165,  pk(0, 0, 1, 0, 1, 1, 1));
        push_b(500,  pk(5, 0, 1, 0, 1, 0, 0));
        repeat (1200) @(posedge clk);
        #2;
        chk("queue_a_drained", qa_cyc.size(), 0);
        chk("queue_b_drained", qb_cyc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
